// File: rtl/local_io_if.sv
// Word-wide local I/O bus: select, address, read strobe, byte write
// enables and write data from the master; read data and ready back.
interface local_io_if;
  logic        sel;
  logic [7:0]  addr;
  logic        r;
  logic [1:0]  w;
  logic [15:0] dwrite;
  logic [15:0] rdata;
  logic        ready;

  modport master (output sel, addr, r, w, dwrite, input rdata, ready);
  modport slave  (input sel, addr, r, w, dwrite, output rdata, ready);
endinterface

// File: rtl/local_io.sv
// Board-level local I/O block: LEDs, 7-seg drive, synchronised switches and
// keys, and a prescaled 16-bit timer with compare interrupt.
//
// state | meaning
// IDLE  | no access in flight; ready drops while a request is presented
// ACK   | access completing; rdata valid, write commits at end of cycle
module local_io (
  input  logic        clk,
  input  logic        nreset,
  local_io_if.slave   bus,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  ledr,
  output logic [7:0]  ledg,
  output logic [15:0] hex,
  output logic        irq
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state;
  logic [6:0]  acc_addr;
  logic [1:0]  acc_be;
  logic [15:0] acc_data;
  logic [15:0] rdata_q;
  logic [15:0] rd_val;

  logic [15:0] count, prescale, compare, pcnt;
  logic        match, ien, run, keyev;
  logic [9:0]  sw_m, sw_s;
  logic [3:0]  key_m, key_s;

  logic        req;
  logic        wr_hit, wr_count, wr_status;
  logic [2:0]  wr_sel;
  logic        tick, key_fall;
  logic [15:0] count_inc;
  logic        unused_addr0;

  // Word access only: the byte-address LSB carries no information.
  assign unused_addr0 = bus.addr[0];

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0]  be);
    merge = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  assign req = bus.sel & (bus.r | (|bus.w));

  // Read mux over the live address; sampled into rdata when an access starts.
  always_comb begin
    rd_val = 16'h0000;
    if (bus.addr[7:4] == 4'h0) begin
      case (bus.addr[3:1])
        3'd0: rd_val = {6'b0, ledr};
        3'd1: rd_val = {8'b0, ledg};
        3'd2: rd_val = hex;
        3'd3: rd_val = {2'b0, key_s, sw_s};
        3'd4: rd_val = count;
        3'd5: rd_val = prescale;
        3'd6: rd_val = compare;
        default: rd_val = {12'b0, keyev, run, ien, match};
      endcase
    end
  end

  // Bus FSM; the access is captured on entry to ACK so the write committed at
  // the end of ACK does not depend on the master holding the bus stable.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      rdata_q  <= 16'h0000;
      acc_addr <= 7'h00;
      acc_be   <= 2'b00;
      acc_data <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= ACK;
            rdata_q  <= bus.r ? rd_val : 16'h0000;
            acc_addr <= bus.addr[7:1];
            acc_be   <= bus.r ? 2'b00 : bus.w;
            acc_data <= bus.dwrite;
          end
        end
        default: begin
          state  <= IDLE;
          acc_be <= 2'b00;
        end
      endcase
    end
  end

  // Ready is forced high in reset so an aborted access never looks stalled.
  assign bus.ready = ~nreset | (state == ACK) | ~req;
  assign bus.rdata = rdata_q;

  assign wr_hit    = (state == ACK) & (|acc_be) & (acc_addr[6:3] == 4'h0);
  assign wr_sel    = acc_addr[2:0];
  assign wr_count  = wr_hit & (wr_sel == 3'd4);
  assign wr_status = wr_hit & (wr_sel == 3'd7) & acc_be[0];

  // Plain read/write registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ledr     <= 10'h000;
      ledg     <= 8'h00;
      hex      <= 16'h0000;
      prescale <= 16'hC34F;
      compare  <= 16'hFFFF;
    end else if (wr_hit) begin
      case (wr_sel)
        3'd0: begin
          if (acc_be[0]) ledr[7:0] <= acc_data[7:0];
          if (acc_be[1]) ledr[9:8] <= acc_data[9:8];
        end
        3'd1: if (acc_be[0]) ledg <= acc_data[7:0];
        3'd2: hex      <= merge(hex, acc_data, acc_be);
        3'd5: prescale <= merge(prescale, acc_data, acc_be);
        3'd6: compare  <= merge(compare, acc_data, acc_be);
        default: ;
      endcase
    end
  end

  assign tick      = run & (pcnt == prescale) & ~wr_count;
  assign count_inc = count + 16'd1;

  // Prescaler and counter; a bus write to COUNT overrides a coincident tick.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= 16'h0000;
      pcnt  <= 16'h0000;
    end else if (wr_count) begin
      count <= merge(count, acc_data, acc_be);
      pcnt  <= 16'h0000;
    end else if (run) begin
      if (pcnt == prescale) begin
        pcnt  <= 16'h0000;
        count <= count_inc;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
    end
  end

  assign key_fall = |(key_s[3:1] & ~key_m[3:1]);

  // Status bits; sticky flags take a new set over a same-cycle W1C clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      match <= 1'b0;
      keyev <= 1'b0;
      ien   <= 1'b0;
      run   <= 1'b0;
    end else begin
      match <= (tick & (count_inc == compare)) | (match & ~(wr_status & acc_data[0]));
      keyev <= key_fall | (keyev & ~(wr_status & acc_data[3]));
      if (wr_status) begin
        ien <= acc_data[1];
        run <= acc_data[2];
      end
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sw_m  <= 10'h000;
      sw_s  <= 10'h000;
      key_m <= 4'h0;
      key_s <= 4'h0;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      key_m <= key;
      key_s <= key_m;
    end
  end

  assign irq = match & ien;

endmodule

// File: tb/tb_local_io.sv
// Bench for local_io: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a register-map model.
module tb_local_io;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic [9:0]  sw = 10'h000;
  logic [3:0]  key = 4'hF;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [15:0] hex;
  logic        irq;
  logic        cmp_en = 1'b0;

  int errors = 0;
  int checks = 0;

  local_io_if bus_if ();

  local_io dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus_if),
    .sw     (sw),
    .key    (key),
    .ledr   (ledr),
    .ledg   (ledg),
    .hex    (hex),
    .irq    (irq)
  );

  always #10 clk = ~clk;

  // Model state: register file indexed by word address, status bits,
  // synchroniser pipeline and the access currently in its second cycle.
  typedef struct packed {
    logic [7:0][15:0] regs;
    logic [15:0] pcnt;
    logic        match, ien, run, keyev;
    logic        ack;
    logic [15:0] rdata;
    logic [7:0]  p_addr;
    logic [1:0]  p_be;
    logic [15:0] p_data;
    logic [9:0]  sw_m, sw_s;
    logic [3:0]  key_m, key_s;
  } model_t;

  model_t m;

  function automatic logic [15:0] wmask(input int idx);
    case (idx)
      0: wmask = 16'h03FF;
      1: wmask = 16'h00FF;
      3, 7: wmask = 16'h0000;
      default: wmask = 16'hFFFF;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t n = '0;
    n.regs[5] = 16'hC34F;
    n.regs[6] = 16'hFFFF;
    return n;
  endfunction

  function automatic logic [15:0] model_read(input model_t s, input logic [7:0] a);
    int idx = int'(a[3:1]);
    if (a[7:4] != 4'h0) return 16'h0000;
    if (idx == 3) return {2'b00, s.key_s, s.sw_s};
    if (idx == 7) return {12'h000, s.keyev, s.run, s.ien, s.match};
    return s.regs[idx];
  endfunction

  function automatic model_t step(input model_t s, input logic sel, input logic [7:0] a,
                                 input logic rd, input logic [1:0] be, input logic [15:0] d,
                                 input logic [9:0] swv, input logic [3:0] keyv);
    model_t n = s;
    int idx = int'(s.p_addr[3:1]);
    logic committing = s.ack && (s.p_be != 2'b00) && (s.p_addr[7:4] == 4'h0);
    logic count_written = committing && idx == 4;
    logic tick = s.run && (s.pcnt == s.regs[5]) && !count_written;
    logic [15:0] next_count = 16'((32'(s.regs[4]) + 1) % 65536);
    logic set_match = tick && (next_count == s.regs[6]);
    logic set_key = |(s.key_s[3:1] & ~s.key_m[3:1]);
    logic clr_match = 1'b0;
    logic clr_key = 1'b0;
    logic [15:0] bm = {{8{s.p_be[1]}}, {8{s.p_be[0]}}};

    n.sw_m = swv;  n.sw_s = s.sw_m;
    n.key_m = keyv; n.key_s = s.key_m;

    if (s.run && !count_written) begin
      n.pcnt = tick ? 16'h0000 : s.pcnt + 16'd1;
      if (tick) n.regs[4] = next_count;
    end

    if (committing) begin
      if (idx == 7) begin
        if (s.p_be[0]) begin
          clr_match = s.p_data[0];
          clr_key   = s.p_data[3];
          n.ien     = s.p_data[1];
          n.run     = s.p_data[2];
        end
      end else if (idx != 3) begin
        n.regs[idx] = ((s.regs[idx] & ~bm) | (s.p_data & bm)) & wmask(idx);
        if (idx == 4) n.pcnt = 16'h0000;
      end
    end

    n.match = set_match || (s.match && !clr_match);
    n.keyev = set_key || (s.keyev && !clr_key);

    if (!s.ack && sel && (rd || be != 2'b00)) begin
      n.ack    = 1'b1;
      n.rdata  = rd ? model_read(s, a) : 16'h0000;
      n.p_addr = a;
      n.p_be   = rd ? 2'b00 : be;
      n.p_data = d;
    end else begin
      n.ack  = 1'b0;
      n.p_be = 2'b00;
    end
    return n;
  endfunction

  // Reference model advances on the same edges as the design.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) m <= model_reset();
    else m <= step(m, bus_if.sel, bus_if.addr, bus_if.r, bus_if.w, bus_if.dwrite, sw, key);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready", bus_if.ready,
          !nreset || m.ack || !(bus_if.sel && (bus_if.r || bus_if.w != 2'b00)));
      chk("m_rdata", bus_if.rdata, m.rdata);
      chk("m_ledr", ledr, m.regs[0][9:0]);
      chk("m_ledg", ledg, m.regs[1][7:0]);
      chk("m_hex", hex, m.regs[2]);
      chk("m_irq", irq, m.match && m.ien);
    end
  end

  task automatic access(input logic [7:0] a, input logic rd, input logic [1:0] be,
                        input logic [15:0] d, output logic [15:0] q);
    @(posedge clk); #1;
    bus_if.sel = 1'b1; bus_if.addr = a; bus_if.r = rd; bus_if.w = be; bus_if.dwrite = d;
    #1 chk("ready_low_idle", bus_if.ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_high_ack", bus_if.ready, 1'b1);
    q = bus_if.rdata;
    bus_if.sel = 1'b0; bus_if.r = 1'b0; bus_if.w = 2'b00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] be, input logic [15:0] d);
    logic [15:0] q;
    access(a, 1'b0, be, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] q;
    access(a, 1'b1, 2'b00, 16'h0000, q);
    chk(name, q, exp);
  endtask

  initial begin
    logic [15:0] q;
    int n;
    bus_if.sel = 1'b0; bus_if.addr = 8'h00; bus_if.r = 1'b0; bus_if.w = 2'b00;
    bus_if.dwrite = 16'h0000;
    #1 nreset = 1'b0;
    #2;
    cmp_en = 1'b1;
    chk("rst_ledr", ledr, 10'h000);
    chk("rst_ledg", ledg, 8'h00);
    chk("rst_hex", hex, 16'h0000);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ready", bus_if.ready, 1'b1);
    chk("rst_rdata", bus_if.rdata, 16'h0000);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    rd_chk("rst_prescale", 8'h0A, 16'hC34F);
    rd_chk("rst_compare", 8'h0C, 16'hFFFF);
    rd_chk("rst_status", 8'h0E, 16'h0000);

    // LEDR full write and readback
    wr(8'h00, 2'b11, 16'h03FF);
    @(posedge clk); #1;
    chk("ledr_written", ledr, 10'h3FF);
    rd_chk("ledr_read", 8'h00, 16'h03FF);

    // HEX byte enables, then read with write strobes also high
    wr(8'h04, 2'b11, 16'hABCD);
    wr(8'h04, 2'b01, 16'h1234);
    @(posedge clk); #1;
    chk("hex_low_byte", hex, 16'hAB34);
    access(8'h04, 1'b1, 2'b11, 16'h5555, q);
    chk("hex_rw_read", q, 16'hAB34);
    @(posedge clk); #1;
    chk("hex_rw_nowrite", hex, 16'hAB34);

    // Timer: tick every 3 clocks, match on the third tick
    wr(8'h0A, 2'b11, 16'h0002);
    wr(8'h0C, 2'b11, 16'h0003);
    wr(8'h0E, 2'b11, 16'h0006);
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (irq) begin n = i; break; end
    end
    chk("irq_latency", n, 9);
    wr(8'h0E, 2'b01, 16'h0003);
    @(posedge clk); #1;
    chk("irq_w1c", irq, 1'b0);

    // Counter wrap, match on wrap to zero, write beats tick
    wr(8'h08, 2'b11, 16'hFFFF);
    wr(8'h0A, 2'b11, 16'h0000);
    wr(8'h0C, 2'b11, 16'h0000);
    wr(8'h0E, 2'b11, 16'h0004);
    @(posedge clk);
    rd_chk("wrap_status", 8'h0E, 16'h0005);
    wr(8'h08, 2'b11, 16'h1234);
    wr(8'h0E, 2'b01, 16'h0001);
    rd_chk("count_write_wins", 8'h08, 16'h1236);
    rd_chk("status_stopped", 8'h0E, 16'h0000);

    // Switch and key synchronisation, key event, unmapped address
    @(posedge clk); #1;
    sw = 10'h155; key = 4'hF;
    repeat (3) @(posedge clk);
    #1 key = 4'h1;
    repeat (4) @(posedge clk);
    rd_chk("input_reg", 8'h06, 16'h0555);
    rd_chk("keyev_set", 8'h0E, 16'h0008);
    rd_chk("unmapped_read", 8'h10, 16'h0000);
    wr(8'h0E, 2'b01, 16'h0008);

    // Reset during the ACK cycle of a write
    @(posedge clk); #1;
    bus_if.sel = 1'b1; bus_if.addr = 8'h02; bus_if.r = 1'b0; bus_if.w = 2'b11;
    bus_if.dwrite = 16'h00AA;
    @(posedge clk); #1;
    nreset = 1'b0;
    #1;
    chk("abort_ledg", ledg, 8'h00);
    chk("abort_ledr", ledr, 10'h000);
    chk("abort_hex", hex, 16'h0000);
    chk("abort_ready", bus_if.ready, 1'b1);
    chk("abort_rdata", bus_if.rdata, 16'h0000);
    chk("abort_irq", irq, 1'b0);
    bus_if.sel = 1'b0; bus_if.w = 2'b00;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    rd_chk("abort_ledg_read", 8'h02, 16'h0000);
    wr(8'h02, 2'b11, 16'h00AA);
    rd_chk("post_reset_write", 8'h02, 16'h00AA);

    // Randomized bus traffic, board inputs and occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [7:0]  a;
      logic [15:0] d;
      @(posedge clk); #1;
      nreset = ($urandom_range(0, 599) != 0);
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      d = 16'($urandom);
      case (a[3:1])
        3'd4: d = 16'($urandom_range(0, 20));
        3'd5: d = 16'($urandom_range(0, 5));
        3'd6: d = 16'($urandom_range(0, 20));
        3'd7: d[2] = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
      bus_if.sel = ($urandom_range(0, 3) != 0);
      bus_if.addr = a;
      bus_if.r = ($urandom_range(0, 2) == 0);
      bus_if.w = 2'($urandom);
      bus_if.dwrite = d;
      if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
      if ($urandom_range(0, 15) == 0) key = 4'($urandom);
    end
    @(posedge clk); #1;
    nreset = 1'b1;
    bus_if.sel = 1'b0; bus_if.r = 1'b0; bus_if.w = 2'b00;
    repeat (4) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/local_io.md
LOCAL_IO -- requirements
Module: local_io

Interface
REQ-001 SHALL have port clk, input, 1 bit: 50 MHz system clock; all state updates on posedge clk.
REQ-002 SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sel, input, 1 bit: bus select, high when bus addr[15:8]==8'hFF (decoded outside this block).
REQ-004 SHALL have port addr, input, 8 bits: bus addr[7:0]; addr[0] ignored (word access).
REQ-005 SHALL have port r, input, 1 bit: read request.
REQ-006 SHALL have port w, input, 2 bits: byte write enables; w[1] = [15:8], w[0] = [7:0].
REQ-007 SHALL have port dwrite, input, 16 bits: write data.
REQ-008 SHALL have port rdata, output, 16 bits: read data.
REQ-009 SHALL have port ready, output, 1 bit: access complete when high.
REQ-010 SHALL have ports sw (input, 10 bits) and key (input, 4 bits): raw board switches and keys, asynchronous to clk.
REQ-011 SHALL have ports ledr (output, 10 bits), ledg (output, 8 bits) and hex (output, 16 bits): LED and 7-seg drive registers.
REQ-012 SHALL have port irq, output, 1 bit: timer interrupt, level.

Function
REQ-013 SHALL decode the register map on addr[3:1]:
  - 0 LEDR: [9:0] RW.
  - 1 LEDG: [7:0] RW.
  - 2 HEX: [15:0] RW.
  - 3 INPUT: RO {2'b0, key_s[3:0], sw_s[9:0]}.
  - 4 COUNT: RW.
  - 5 PRESCALE: RW.
  - 6 COMPARE: RW.
  - 7 STATUS: bit0 match (W1C), bit1 ien RW, bit2 run RW, bit3 keyev (W1C); other bits read 0.
  - Unimplemented bits SHALL read 0; addr[7:4] != 0 SHALL read 16'h0000 and ignore writes.
REQ-014 SHALL run a bus FSM with states IDLE and ACK.
  - IDLE with sel & (r | |w): ready=0 (combinational), next state ACK.
  - In ACK: ready=1 and rdata valid; next state IDLE.
  - Without sel: ready=1.
REQ-015 SHALL take exactly 2 cycles per access; a request held past ACK SHALL start a new access.
REQ-016 SHALL commit writes at the end of the ACK cycle, honouring w[1] and w[0] independently per byte.
REQ-017 SHALL treat r and w both high as a read, with no write.
REQ-018 SHALL register rdata in IDLE→ACK and hold it to the next access; rdata SHALL be 0 when the access was not a read.
REQ-019 SHALL synchronise sw and key through two flops (sw_s, key_s).
REQ-020 SHALL set keyev on a falling edge of any key_s[3:1].
REQ-021 SHALL run the prescaler when run=1: pcnt increments each clk; when pcnt==PRESCALE, pcnt←0 and a tick occurs; while run=0, pcnt and COUNT hold.
REQ-022 SHALL increment COUNT on each tick, modulo 2^16 (16'hFFFF→16'h0000).
REQ-023 SHALL set match when a tick makes COUNT equal to COMPARE; a COUNT write equal to COMPARE SHALL NOT set match.
REQ-024 SHALL, on a COUNT write, load COUNT and clear pcnt; a bus write SHALL win over a tick in the same cycle.
REQ-025 SHALL give set priority over a W1C clear when both occur in the same cycle (match and keyev).
REQ-026 SHALL drive irq = match & ien, registered-state only, with no glitch path from the bus.

Reset
REQ-027 SHALL, on nreset low, immediately set:
  - ledr=0, ledg=0, hex=0.
  - COUNT=0, pcnt=0, PRESCALE=16'hC34F, COMPARE=16'hFFFF.
  - match=0, ien=0, run=0, keyev=0.
  - sync flops = 0.
  - state=IDLE, rdata=0, ready=1, irq=0.
REQ-028 SHALL, on reset asserted mid-access, abort the access with no write committed, and SHALL accept the first access after release as a new access.

Verification
REQ-029 Write LEDR 16'h03FF with w=2'b11, then read -> ready low 1 cycle, ledr=10'h3FF, read returns 16'h03FF in ACK.
REQ-030 Write HEX 16'hABCD, then HEX 16'h1234 with w=2'b01 -> hex=16'hAB34; r and w both high on HEX -> returns 16'hAB34, unchanged.
REQ-031 PRESCALE=2, COMPARE=3, STATUS=16'h0006 -> COUNT increments every 3 clks; match and irq rise 9 clks after run; W1C STATUS bit0 -> irq low.
REQ-032 COUNT=16'hFFFF, PRESCALE=0, run -> next tick COUNT=0; COMPARE=0 -> match set; COUNT write on tick cycle -> written value held.
REQ-033 sw=10'h155 and key[3:1] toggled low -> INPUT reads 16'h??55-based value {key_s, 10'h155} after ≥2 clks, keyev=1; read of addr 8'h10 returns 0.
REQ-034 nreset pulsed during an ACK write cycle -> target register keeps its reset value, ready=1, all outputs at REQ-027 values.
